// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register for a 5-stage RV32I core.
// Decodes IF/ID, reads/bypasses operands, builds immediates and control, and inserts load-use bubbles.
module id_ex_stage #(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrc,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic            ex_lui,
  output logic            ex_auipc
);

  typedef struct packed {
    logic regwrite, memread, memwrite, memtoreg, alusrc;
    logic branch, jal, jalr, lui, auipc;
  } ctrl_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic [6:0]      opcode;
  logic [4:0]      dec_rd;
  ctrl_t           dec_ctrl;
  logic [31:0]     dec_imm;
  logic            use_rs1, use_rs2, lu;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] opnd1, opnd2;

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]      f3_q, f3_d;
  logic            f7b5_q, f7b5_d;

  assign opcode = if_instr[6:0];
  assign dec_rd = if_instr[11:7];
  assign rf_rs1 = if_instr[19:15];
  assign rf_rs2 = if_instr[24:20];

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'h000};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

  always_comb begin
    dec_ctrl = '0;
    dec_imm  = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    unique case (opcode)
      OP_R:      begin dec_ctrl.regwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I:      begin dec_ctrl.regwrite = 1'b1; dec_ctrl.alusrc = 1'b1; dec_imm = imm_i; use_rs1 = 1'b1; end
      OP_LOAD:   begin
        dec_ctrl.regwrite = 1'b1; dec_ctrl.memread = 1'b1; dec_ctrl.memtoreg = 1'b1;
        dec_ctrl.alusrc = 1'b1; dec_imm = imm_i; use_rs1 = 1'b1;
      end
      OP_STORE:  begin
        dec_ctrl.memwrite = 1'b1; dec_ctrl.alusrc = 1'b1; dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BRANCH: begin dec_ctrl.branch = 1'b1; dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL:    begin dec_ctrl.regwrite = 1'b1; dec_ctrl.jal = 1'b1; dec_imm = imm_j; end
      OP_JALR:   begin
        dec_ctrl.regwrite = 1'b1; dec_ctrl.jalr = 1'b1; dec_ctrl.alusrc = 1'b1; dec_imm = imm_i; use_rs1 = 1'b1;
      end
      OP_LUI:    begin dec_ctrl.regwrite = 1'b1; dec_ctrl.lui = 1'b1; dec_imm = imm_u; end
      OP_AUIPC:  begin dec_ctrl.regwrite = 1'b1; dec_ctrl.auipc = 1'b1; dec_imm = imm_u; end
      default:   ;
    endcase
    if (dec_rd == 5'd0) dec_ctrl.regwrite = 1'b0;
  end

  // x0 reads as zero; a same-cycle WB write to the indexed register wins over the stale RF value.
  function automatic logic [XLEN-1:0] read_opnd(input logic [4:0] idx, input logic [XLEN-1:0] rfd,
                                                input logic we, input logic [4:0] wrd,
                                                input logic [XLEN-1:0] wdata);
    if (idx == 5'd0) return '0;
    if (WB_BYPASS && we && (wrd == idx)) return wdata;
    return rfd;
  endfunction

  assign opnd1 = read_opnd(rf_rs1, rf_data1, wb_regwrite, wb_rd, wb_data);
  assign opnd2 = read_opnd(rf_rs2, rf_data2, wb_regwrite, wb_rd, wb_data);

  assign lu = if_valid && valid_q && ctrl_q.memread && (rd_q != 5'd0) &&
              ((use_rs1 && (rd_q == rf_rs1)) || (use_rs2 && (rd_q == rf_rs2)));

  // Handshake: IF/ID offers if_valid every cycle; id_stall=1 means it was not taken and must be
  // re-presented unchanged. ex_hold freezes this stage; ex_flush kills the ID instruction and wins.
  assign id_stall = rst & ~ex_flush & (ex_hold | lu);

  always_comb begin
    valid_d = valid_q;  ctrl_d = ctrl_q;  pc_d = pc_q;  op1_d = op1_q;  op2_d = op2_q;
    imm_d   = imm_q;    rd_d   = rd_q;    rs1_d = rs1_q; rs2_d = rs2_q; f3_d = f3_q;  f7b5_d = f7b5_q;
    if (ex_flush || (!ex_hold && lu)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!ex_hold) begin
      valid_d = if_valid;
      ctrl_d  = if_valid ? dec_ctrl : '0;
      pc_d    = if_pc;
      op1_d   = opnd1;
      op2_d   = opnd2;
      imm_d   = dec_imm;
      rd_d    = dec_rd;
      rs1_d   = rf_rs1;
      rs2_d   = rf_rs2;
      f3_d    = if_instr[14:12];
      f7b5_d  = if_instr[30];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0; ctrl_q <= '0; pc_q <= '0; op1_q <= '0; op2_q <= '0; imm_q <= '0;
      rd_q    <= '0;   rs1_q  <= '0; rs2_q <= '0; f3_q <= '0; f7b5_q <= 1'b0;
    end else begin
      valid_q <= valid_d; ctrl_q <= ctrl_d; pc_q <= pc_d; op1_q <= op1_d; op2_q <= op2_d; imm_q <= imm_d;
      rd_q    <= rd_d;    rs1_q  <= rs1_d;  rs2_q <= rs2_d; f3_q <= f3_d; f7b5_q <= f7b5_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_op1      = op1_q;
  assign ex_op2      = op2_q;
  assign ex_imm      = imm_q;
  assign ex_rd       = rd_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_funct3   = f3_q;
  assign ex_funct7b5 = f7b5_q;
  assign {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
          ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc} = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, an instruction-level reference model checked every
// cycle, and hand-computed literal expectations for the key scenarios.
module tb_id_ex_stage;

  logic        clk, rst, if_valid, wb_regwrite, ex_flush, ex_hold;
  logic [31:0] if_instr, if_pc, rf_data1, rf_data2, wb_data;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd;
  logic        id_stall, ex_valid, ex_funct7b5;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic        ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_lui(ex_lui), .ex_auipc(ex_auipc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // ctrl bit order: regwrite memread memwrite memtoreg alusrc branch jal jalr lui auipc
  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] pc, op1, op2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
  } ex_t;

  ex_t m;

  function automatic void classify(input logic [31:0] ins, output logic [9:0] c,
                                   output logic [31:0] imm, output logic u1, output logic u2);
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    i_imm = 32'(signed'(ins[31:20]));
    s_imm = 32'(signed'({ins[31:25], ins[11:7]}));
    b_imm = 32'(signed'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    u_imm = {ins[31:12], 12'h000};
    j_imm = 32'(signed'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    c = '0; imm = '0; u1 = 1'b0; u2 = 1'b0;
    case (ins[6:0])
      7'b0110011: begin c = 10'b1000000000; u1 = 1'b1; u2 = 1'b1; end
      7'b0010011: begin c = 10'b1000100000; imm = i_imm; u1 = 1'b1; end
      7'b0000011: begin c = 10'b1101100000; imm = i_imm; u1 = 1'b1; end
      7'b0100011: begin c = 10'b0010100000; imm = s_imm; u1 = 1'b1; u2 = 1'b1; end
      7'b1100011: begin c = 10'b0000010000; imm = b_imm; u1 = 1'b1; u2 = 1'b1; end
      7'b1101111: begin c = 10'b1000001000; imm = j_imm; end
      7'b1100111: begin c = 10'b1000100100; imm = i_imm; u1 = 1'b1; end
      7'b0110111: begin c = 10'b1000000010; imm = u_imm; end
      7'b0010111: begin c = 10'b1000000001; imm = u_imm; end
      default: ;
    endcase
    if (ins[11:7] == 5'd0) c[9] = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic [31:0] rfd);
    if (idx == 5'd0) return 32'd0;
    if (wb_regwrite && wb_rd == idx) return wb_data;
    return rfd;
  endfunction

  function automatic logic model_lu();
    logic [9:0] c; logic [31:0] imm; logic u1, u2;
    classify(if_instr, c, imm, u1, u2);
    return if_valid && m.valid && m.ctrl[8] && m.rd != 5'd0 &&
           ((u1 && m.rd == if_instr[19:15]) || (u2 && m.rd == if_instr[24:20]));
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [9:0] c; logic [31:0] imm; logic u1, u2;
    if (!rst) begin
      m <= '0;
    end else if (ex_flush || (!ex_hold && model_lu())) begin
      m.valid <= 1'b0;
      m.ctrl  <= '0;
    end else if (!ex_hold) begin
      classify(if_instr, c, imm, u1, u2);
      m.valid <= if_valid;
      m.ctrl  <= if_valid ? c : 10'd0;
      m.pc    <= if_pc;
      m.op1   <= model_read(if_instr[19:15], rf_data1);
      m.op2   <= model_read(if_instr[24:20], rf_data2);
      m.imm   <= imm;
      m.rd    <= if_instr[11:7];
      m.rs1   <= if_instr[19:15];
      m.rs2   <= if_instr[24:20];
      m.f3    <= if_instr[14:12];
      m.f7b5  <= if_instr[30];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic report(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: expectation queue empty, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      report(name, 64'(act), 64'(e));
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] e);
    exp_q.push_back(e);
    chk(name, act);
  endtask

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = rst && !ex_flush && (ex_hold || model_lu());
    report("id_stall", 64'(id_stall), 64'(exp_stall));
    report("rf_addr", 64'({rf_rs1, rf_rs2}), 64'({if_instr[19:15], if_instr[24:20]}));
    report("valid_ctrl",
           64'({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
                ex_branch, ex_jal, ex_jalr, ex_lui, ex_auipc}),
           64'({m.valid, m.ctrl}));
    if (m.valid) begin
      report("pc", 64'(ex_pc), 64'(m.pc));
      report("op1_op2", {ex_op1, ex_op2}, {m.op1, m.op2});
      report("imm", 64'(ex_imm), 64'(m.imm));
      report("fields", 64'({ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_funct7b5}),
             64'({m.rd, m.rs1, m.rs2, m.f3, m.f7b5}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
    if_valid = v; if_instr = ins; if_pc = pc; rf_data1 = d1; rf_data2 = d2;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_regwrite = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [31:0] I_ADDI  = 32'hFFD08293;  // addi x5,x1,-3
  localparam logic [31:0] I_ADD   = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] I_ADD0  = 32'h002001B3;  // add  x3,x0,x2
  localparam logic [31:0] I_LW    = 32'h00012203;  // lw   x4,0(x2)
  localparam logic [31:0] I_ADD44 = 32'h00420333;  // add  x6,x4,x4
  localparam logic [31:0] I_LUI   = 32'h00020337;  // lui  x6,0x20 (rs1 field happens to be 4)
  localparam logic [31:0] I_AUIPC = 32'h00001397;  // auipc x7,1
  localparam logic [31:0] I_JALR0 = 32'h00008067;  // jalr x0,0(x1)

  logic [31:0] mix_tbl [7];

  initial begin
    mix_tbl[0] = 32'h0020A423;  // sw   x2,8(x1)
    mix_tbl[1] = 32'hFE208EE3;  // beq  x1,x2,-4
    mix_tbl[2] = 32'h008000EF;  // jal  x1,+8
    mix_tbl[3] = I_JALR0;
    mix_tbl[4] = I_AUIPC;
    mix_tbl[5] = 32'hFFFFFFFF;  // undefined opcode
    mix_tbl[6] = 32'h40F35333;  // sra-style R word with funct7b5 set

    rst = 1'b1;
    set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    ex_flush = 1'b0; ex_hold = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    expect_eq("post_reset_valid", 32'(ex_valid), 32'd0);

    // ADDI x5,x1,-3 with rf_data1=10
    set_in(1'b1, I_ADDI, 32'h100, 32'd10, 32'd0);
    step();
    exp_q.push_back(32'd10); exp_q.push_back(32'hFFFFFFFD); exp_q.push_back(32'd5);
    exp_q.push_back(32'd1);  exp_q.push_back(32'd1);         exp_q.push_back(32'd1);
    chk("addi_op1", ex_op1);
    chk("addi_imm", ex_imm);
    chk("addi_rd", 32'(ex_rd));
    chk("addi_regwrite", 32'(ex_regwrite));
    chk("addi_alusrc", 32'(ex_alusrc));
    chk("addi_valid", 32'(ex_valid));

    // Asynchronous reset mid-stream while holding, so a stall would otherwise be asserted
    ex_hold = 1'b1;
    #2 rst = 1'b0;
    #1;
    expect_eq("arst_valid", 32'(ex_valid), 32'd0);
    expect_eq("arst_op1", ex_op1, 32'd0);
    expect_eq("arst_imm", ex_imm, 32'd0);
    expect_eq("arst_ctrl", 32'({ex_regwrite, ex_alusrc, ex_rd}), 32'd0);
    expect_eq("arst_stall", 32'(id_stall), 32'd0);
    ex_hold = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // WB bypass of rs1, then wb_rd=0 (no bypass), then rs1=x0 reads zero
    set_in(1'b1, I_ADD, 32'h104, 32'h1111, 32'h2222);
    set_wb(1'b1, 5'd1, 32'hDEAD);
    step();
    expect_eq("byp_op1", ex_op1, 32'hDEAD);
    expect_eq("byp_op2", ex_op2, 32'h2222);
    set_wb(1'b1, 5'd0, 32'hDEAD);
    step();
    expect_eq("nobyp_op1", ex_op1, 32'h1111);
    set_in(1'b1, I_ADD0, 32'h108, 32'h9999, 32'h2222);
    set_wb(1'b1, 5'd0, 32'hBEEF);
    step();
    expect_eq("x0_op1", ex_op1, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);

    // Load-use: LW x4 in EX, ADD x6,x4,x4 in ID
    set_in(1'b1, I_LW, 32'h200, 32'h1000, 32'd0);
    step();
    expect_eq("lw_memread", 32'(ex_memread), 32'd1);
    set_in(1'b1, I_ADD44, 32'h204, 32'h7777, 32'h7777);
    #1 expect_eq("lu_stall", 32'(id_stall), 32'd1);
    step();
    expect_eq("lu_bubble", 32'({ex_valid, ex_memread, ex_regwrite}), 32'd0);
    set_wb(1'b1, 5'd4, 32'h55);
    #1 expect_eq("lu_stall_once", 32'(id_stall), 32'd0);
    step();
    expect_eq("lu_issue_valid", 32'(ex_valid), 32'd1);
    expect_eq("lu_issue_pc", ex_pc, 32'h204);
    expect_eq("lu_issue_ops", {ex_op1[15:0], ex_op2[15:0]}, 32'h00550055);
    set_wb(1'b0, 5'd0, 32'd0);

    // Same with LUI x6 in ID: no source used, no stall
    set_in(1'b1, I_LW, 32'h210, 32'h1000, 32'd0);
    step();
    set_in(1'b1, I_LUI, 32'h214, 32'h7777, 32'h7777);
    #1 expect_eq("lui_nostall", 32'(id_stall), 32'd0);
    step();
    expect_eq("lui_flag", 32'({ex_valid, ex_lui, ex_regwrite}), 32'd7);
    expect_eq("lui_imm", ex_imm, 32'h00020000);

    // Mixed classes and an invalid slot, checked by the model
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, mix_tbl[i], 32'h300 + 32'(i * 4), $urandom, $urandom);
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      step();
      if (i == 3) expect_eq("jalr_x0", 32'({ex_regwrite, ex_jalr, ex_alusrc}), 32'd3);
      if (i == 5) expect_eq("undef_op", {ex_imm[30:0], ex_valid}, 32'd1);
    end
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b0, I_ADD, 32'h400, 32'd1, 32'd2);
    step();
    expect_eq("invalid_slot", 32'({ex_valid, ex_regwrite}), 32'd0);

    // Hold for three cycles
    set_in(1'b1, I_AUIPC, 32'h500, 32'd0, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, I_ADD, 32'h504 + 32'(i * 4), $urandom, $urandom);
      ex_hold = 1'b1;
      #1 expect_eq("hold_stall", 32'(id_stall), 32'd1);
      step();
      expect_eq("hold_pc", ex_pc, 32'h500);
      expect_eq("hold_ctrl", 32'({ex_valid, ex_auipc, ex_imm[12]}), 32'd7);
    end

    // Flush wins over hold
    ex_flush = 1'b1;
    set_in(1'b1, I_ADDI, 32'h600, 32'd1, 32'd1);
    #1 expect_eq("flush_stall", 32'(id_stall), 32'd0);
    step();
    expect_eq("flush_valid", 32'(ex_valid), 32'd0);
    ex_flush = 1'b0; ex_hold = 1'b0;
    step();
    expect_eq("after_flush_rd", 32'(ex_rd), 32'd5);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
